// File: rtl/spi_master_cfg.sv
// Purpose: full-duplex SPI master, per-transfer CPOL/CPHA, fixed SCLK divider, NUM_CS selects.
// Latency: busy 2*CS_DELAY + 2*DATALENGTH*CLK_DIV + 1 + IDLE_GAP cycles per word; done is a 1-cycle pulse.
// Backpressure: start is a level sampled only in IDLE; any start seen while busy is ignored.
//
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first input (latched at start).
// Ports: clk/reset_n (async active-low); start/cpol/cpha/cs_sel/data_in control one word;
//        miso/mosi/sclk/cs_n form the SPI bus; data_out/done report the received word;
//        busy covers SETUP through GAP.
module spi_master_cfg #(
    parameter int DATALENGTH = 16,
    parameter int NUM_CS     = 4,
    parameter int CLK_DIV    = 2,
    parameter int CS_DELAY   = 2,
    parameter int IDLE_GAP   = 2,
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [CSW-1:0]        cs_sel,
    input  logic [DATALENGTH-1:0] data_in,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    input  logic                  miso,
    output logic [DATALENGTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  sclk,
    output logic                  mosi
);

    localparam int BW     = $clog2(DATALENGTH) + 1;
    localparam int TMAX_A = (CLK_DIV > CS_DELAY) ? CLK_DIV : CS_DELAY;
    localparam int TMAX   = (TMAX_A > IDLE_GAP) ? TMAX_A : IDLE_GAP;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] CS_LAST  = TW'(CS_DELAY - 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATALENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_GAP
    } state_t;

    state_t                state, state_nxt;
    logic [TW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATALENGTH-1:0] tx_sh, rx_sh, tx_word, rx_word;
    logic                  cpol_l, cpha_l, lsb_l, lsb_in;
    logic [CSW-1:0]        cs_l, sel_nxt;
    logic [NUM_CS-1:0]     cs_n_nxt;
    logic                  sclk_edge, lead_edge, sample_edge, drive_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // LSB-first is handled by reversing the word at both ends so the shifters stay MSB-first.
    always_comb begin
        tx_word = data_in;
        rx_word = rx_sh;
        if (lsb_in) begin
            for (int i = 0; i < DATALENGTH; i++) tx_word[i] = data_in[DATALENGTH-1-i];
        end
        if (lsb_l) begin
            for (int i = 0; i < DATALENGTH; i++) rx_word[i] = rx_sh[DATALENGTH-1-i];
        end
    end

    // An edge is due at the end of each CLK_DIV-cycle half period; it is a leading
    // edge when sclk still sits at its idle level.
    assign sclk_edge   = (state == S_SHIFT) && (cnt == DIV_LAST);
    assign lead_edge   = (sclk == cpol_l);
    assign sample_edge = sclk_edge && (lead_edge != cpha_l);
    assign drive_edge  = sclk_edge && (lead_edge == cpha_l);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: if (cnt == CS_LAST) state_nxt = S_SHIFT;
            // bit_cnt counts completed trailing edges, so the last one closes SHIFT
            S_SHIFT: if (sclk_edge && !lead_edge && (bit_cnt == BIT_LAST)) state_nxt = S_HOLD;
            S_HOLD:  if (cnt == CS_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Chip-select decode looks ahead at the next state so cs_n is a plain flop.
    always_comb begin
        sel_nxt  = (state == S_IDLE) ? cs_sel : cs_l;
        cs_n_nxt = '1;
        if (state_nxt inside {S_SETUP, S_SHIFT, S_HOLD}) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (int'(sel_nxt) == i) cs_n_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cs_n  <= '1;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || sclk_edge) cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
            busy  <= (state_nxt != S_IDLE);
            done  <= (state_nxt == S_DONE);
            cs_n  <= cs_n_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            data_out <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
            cs_l     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sclk    <= cpol;
                    bit_cnt <= '0;
                    if (start) begin
                        cpol_l <= cpol;
                        cpha_l <= cpha;
                        lsb_l  <= lsb_in;
                        cs_l   <= cs_sel;
                        // CPHA=0 slaves sample on the first edge, so bit 0 goes out now.
                        if (!cpha) begin
                            mosi  <= tx_word[DATALENGTH-1];
                            tx_sh <= {tx_word[DATALENGTH-2:0], 1'b0};
                        end else begin
                            tx_sh <= tx_word;
                        end
                    end
                end
                S_SHIFT: begin
                    if (sclk_edge) begin
                        sclk <= ~sclk;
                        if (!lead_edge) bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (sample_edge) rx_sh <= {rx_sh[DATALENGTH-2:0], miso};
                    if (drive_edge) begin
                        mosi  <= tx_sh[DATALENGTH-1];
                        tx_sh <= {tx_sh[DATALENGTH-2:0], 1'b0};
                    end
                end
                S_HOLD: begin
                    if (state_nxt == S_DONE) data_out <= rx_word;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
